// File: rtl/mem_req_arbiter.sv
// Two-client memory request arbiter with in-order response routing via a tracking FIFO.
// Optional: define MEM_REQ_ARBITER_FIXED_PRIO_EN for fixed priority (client 0 wins ties).
module mem_req_arbiter #(
    parameter int unsigned p_req_bits  = 74,
    parameter int unsigned p_resp_bits = 74,
    parameter int unsigned p_depth     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                c_req_val,
    output logic [1:0]                c_req_rdy,
    input  logic [2*p_req_bits-1:0]   c_req_msg,
    output logic [1:0]                c_resp_val,
    input  logic [1:0]                c_resp_rdy,
    output logic [p_resp_bits-1:0]    c_resp_msg,
    output logic                      mem_req_val,
    input  logic                      mem_req_rdy,
    output logic [p_req_bits-1:0]     mem_req_msg,
    input  logic                      mem_resp_val,
    output logic                      mem_resp_rdy,
    input  logic [p_resp_bits-1:0]    mem_resp_msg
);

    localparam int unsigned PtrW = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic               win_c;
    logic [1:0]         grant_c;
    logic               full_c;
    logic               empty_c;
    logic               push_c;
    logic               pop_c;
    logic               head_c;

    logic [p_depth-1:0] id_q,     id_d;
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q,  count_d;

`ifdef MEM_REQ_ARBITER_FIXED_PRIO_EN
    // Client 1 only wins when client 0 is idle.
    assign win_c = ~c_req_val[0];
`else
    logic prio_q, prio_d;

    // On a tie the pointer picks; otherwise the sole valid client wins.
    assign win_c  = (&c_req_val) ? prio_q : c_req_val[1];
    assign prio_d = push_c ? ~win_c : prio_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    assign grant_c = c_req_val & (win_c ? 2'b10 : 2'b01);
    assign full_c  = (count_q == CntW'(p_depth));
    assign empty_c = (count_q == '0);

    assign mem_req_val = (|c_req_val) & ~full_c;
    assign mem_req_msg = win_c ? c_req_msg[p_req_bits +: p_req_bits]
                               : c_req_msg[0 +: p_req_bits];
    assign c_req_rdy   = grant_c & {2{mem_req_rdy & ~full_c}};
    assign push_c      = mem_req_val & mem_req_rdy;

    // Responses return in order, so the FIFO head names the owner.
    assign head_c       = id_q[rd_ptr_q];
    assign c_resp_val   = {head_c, ~head_c} & {2{mem_resp_val & ~empty_c}};
    assign c_resp_msg   = mem_resp_msg;
    assign mem_resp_rdy = ~empty_c & c_resp_rdy[head_c];
    assign pop_c        = mem_resp_val & mem_resp_rdy;

    always_comb begin
        id_d     = id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            id_d[wr_ptr_q] = win_c;
            wr_ptr_d       = wr_ptr_q + PtrW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            id_q     <= id_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter (p_depth=4).
module tb_mem_req_arbiter;

    localparam int unsigned ReqW  = 74;
    localparam int unsigned RespW = 74;

    localparam logic [ReqW-1:0]  MSG0 = 74'h1_2345_6789_ABCD_EF01;
    localparam logic [ReqW-1:0]  MSG1 = 74'h2_FEDC_BA98_7654_3210;
    localparam logic [RespW-1:0] R0   = 74'h0_0000_0000_0000_00A0;
    localparam logic [RespW-1:0] R1   = 74'h3_1111_2222_3333_4444;
    localparam logic [RespW-1:0] R2   = 74'h0_5555_6666_7777_8888;
    localparam logic [RespW-1:0] R3   = 74'h1_9999_AAAA_BBBB_CCCC;

    logic              clk;
    logic              rst;
    logic [1:0]        c_req_val;
    logic [1:0]        c_req_rdy;
    logic [2*ReqW-1:0] c_req_msg;
    logic [1:0]        c_resp_val;
    logic [1:0]        c_resp_rdy;
    logic [RespW-1:0]  c_resp_msg;
    logic              mem_req_val;
    logic              mem_req_rdy;
    logic [ReqW-1:0]   mem_req_msg;
    logic              mem_resp_val;
    logic              mem_resp_rdy;
    logic [RespW-1:0]  mem_resp_msg;

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_q[$];
    logic [1:0] cont_exp [4];
    logic [1:0] hold_rdy;

    mem_req_arbiter #(
        .p_req_bits (ReqW),
        .p_resp_bits(RespW),
        .p_depth    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .c_req_val   (c_req_val),
        .c_req_rdy   (c_req_rdy),
        .c_req_msg   (c_req_msg),
        .c_resp_val  (c_resp_val),
        .c_resp_rdy  (c_resp_rdy),
        .c_resp_msg  (c_resp_msg),
        .mem_req_val (mem_req_val),
        .mem_req_rdy (mem_req_rdy),
        .mem_req_msg (mem_req_msg),
        .mem_resp_val(mem_resp_val),
        .mem_resp_rdy(mem_resp_rdy),
        .mem_resp_msg(mem_resp_msg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [73:0] got, input logic [73:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] oh(input bit id);
        return id ? 2'b10 : 2'b01;
    endfunction

    initial begin
`ifdef MEM_REQ_ARBITER_FIXED_PRIO_EN
        cont_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        cont_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        rst          = 1'b0;
        c_req_val    = 2'b11;
        mem_req_rdy  = 1'b1;
        c_resp_rdy   = 2'b11;
        mem_resp_val = 1'b0;
        c_req_msg    = {MSG1, MSG0};
        mem_resp_msg = R0;

        // Reset held for two cycles
        @(negedge clk); #1;
        check("rst_c_resp_val", 74'(c_resp_val), 74'(2'b00));
        check("rst_mem_resp_rdy", 74'(mem_resp_rdy), 74'(1'b0));
        @(negedge clk);
        rst = 1'b1;

        // Contention: four accepted requests fill the FIFO
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("cont_grant%0d", i), 74'(c_req_rdy), 74'(cont_exp[i]));
            check($sformatf("cont_val%0d", i), 74'(mem_req_val), 74'(1'b1));
            check($sformatf("cont_msg%0d", i), mem_req_msg, (cont_exp[i] == 2'b01) ? MSG0 : MSG1);
            check($sformatf("cont_noresp%0d", i), 74'(c_resp_val), 74'(2'b00));
            exp_q.push_back(cont_exp[i] == 2'b10);
            @(negedge clk);
        end

        // Full: requests blocked
        #1;
        check("full_req_val", 74'(mem_req_val), 74'(1'b0));
        check("full_req_rdy", 74'(c_req_rdy), 74'(2'b00));
        check("full_resp_val", 74'(c_resp_val), 74'(2'b00));
        @(negedge clk);

        // Pop while full: no bypass push
        mem_resp_val = 1'b1;
        #1;
        check("pop_resp_val", 74'(c_resp_val), 74'(oh(exp_q[0])));
        check("pop_resp_rdy", 74'(mem_resp_rdy), 74'(1'b1));
        check("pop_resp_msg", c_resp_msg, R0);
        check("pop_no_bypass", 74'(mem_req_val), 74'(1'b0));
        void'(exp_q.pop_front());
        @(negedge clk);

        // Requests re-enabled after the pop
        mem_resp_val = 1'b0;
        c_req_val    = 2'b10;
        #1;
        check("reen_req_val", 74'(mem_req_val), 74'(1'b1));
        check("reen_req_rdy", 74'(c_req_rdy), 74'(2'b10));
        check("reen_req_msg", mem_req_msg, MSG1);
        exp_q.push_back(1'b1);
        @(negedge clk);

        // Back-pressure: head client not ready
        c_req_val    = 2'b00;
        mem_resp_val = 1'b1;
        hold_rdy     = ~oh(exp_q[0]);
        c_resp_rdy   = hold_rdy;
        #1;
        check("bp_resp_rdy", 74'(mem_resp_rdy), 74'(1'b0));
        check("bp_resp_val", 74'(c_resp_val), 74'(oh(exp_q[0])));
        @(negedge clk); #1;
        check("bp_hold_val", 74'(c_resp_val), 74'(oh(exp_q[0])));
        check("bp_hold_rdy", 74'(mem_resp_rdy), 74'(1'b0));
        @(negedge clk);
        c_resp_rdy = 2'b11;
        #1;
        check("bp_release", 74'(mem_resp_rdy), 74'(1'b1));
        void'(exp_q.pop_front());
        @(negedge clk); #1;

        // Drain one more to reach count 2
        check("drain_val", 74'(c_resp_val), 74'(oh(exp_q[0])));
        check("drain_rdy", 74'(mem_resp_rdy), 74'(1'b1));
        void'(exp_q.pop_front());
        @(negedge clk);

        // Simultaneous push and pop at count 2
        c_req_val = 2'b01;
        #1;
        check("sim_req_rdy", 74'(c_req_rdy), 74'(2'b01));
        check("sim_resp_val", 74'(c_resp_val), 74'(oh(exp_q[0])));
        check("sim_resp_rdy", 74'(mem_resp_rdy), 74'(1'b1));
        void'(exp_q.pop_front());
        exp_q.push_back(1'b0);
        @(negedge clk);
        c_req_val = 2'b00;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("sim_drain_val%0d", i), 74'(c_resp_val), 74'(oh(exp_q[0])));
            check($sformatf("sim_drain_rdy%0d", i), 74'(mem_resp_rdy), 74'(1'b1));
            void'(exp_q.pop_front());
            @(negedge clk);
        end

        // Empty: stray response stalls
        #1;
        check("empty_resp_rdy", 74'(mem_resp_rdy), 74'(1'b0));
        check("empty_resp_val", 74'(c_resp_val), 74'(2'b00));
        @(negedge clk);

        // Routing: issue 1,0,1 then deliver in order
        mem_resp_val = 1'b0;
        c_req_val = 2'b10; #1; check("rt_issue0", 74'(c_req_rdy), 74'(2'b10)); @(negedge clk);
        c_req_val = 2'b01; #1; check("rt_issue1", 74'(c_req_rdy), 74'(2'b01)); @(negedge clk);
        c_req_val = 2'b10; #1; check("rt_issue2", 74'(c_req_rdy), 74'(2'b10)); @(negedge clk);
        c_req_val    = 2'b00;
        mem_resp_val = 1'b1;
        mem_resp_msg = R1; #1;
        check("rt_val0", 74'(c_resp_val), 74'(2'b10)); check("rt_msg0", c_resp_msg, R1);
        @(negedge clk);
        mem_resp_msg = R2; #1;
        check("rt_val1", 74'(c_resp_val), 74'(2'b01)); check("rt_msg1", c_resp_msg, R2);
        @(negedge clk);
        mem_resp_msg = R3; #1;
        check("rt_val2", 74'(c_resp_val), 74'(2'b10)); check("rt_msg2", c_resp_msg, R3);
        @(negedge clk); #1;
        check("rt_empty", 74'(mem_resp_rdy), 74'(1'b0));
        @(negedge clk);

        // Reset mid-operation discards tracking entries
        mem_resp_val = 1'b0;
        c_req_val    = 2'b11;
        @(negedge clk);
        @(negedge clk);
        c_req_val = 2'b00;
        rst       = 1'b0;
        @(negedge clk);
        rst          = 1'b1;
        mem_resp_val = 1'b1;
        #1;
        check("mrst_resp_rdy", 74'(mem_resp_rdy), 74'(1'b0));
        check("mrst_resp_val", 74'(c_resp_val), 74'(2'b00));
        @(negedge clk);
        mem_resp_val = 1'b0;
        c_req_val    = 2'b11;
        #1;
        check("mrst_grant", 74'(c_req_rdy), 74'(2'b01));
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
